// File: rtl/dpram_rw_pipe.sv
// Dual-port RAM with byte-enabled writes, write-first read bypass and a
// 1- or 2-stage registered read pipeline; optional zero-fill after reset.
module dpram_rw_pipe #(
    parameter int unsigned RAM_SIZE      = 1024,
    parameter int unsigned ADDR_WIDTH    = 10,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned READ_LATENCY  = 1,
    parameter int unsigned INIT_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    rst_b,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [ADDR_WIDTH-1:0]   write_addr,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic                    rd,
    input  logic [ADDR_WIDTH-1:0]   read_addr,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    data_valid,
    output logic                    init_busy
);

    localparam int                    BE_WIDTH  = int'(DATA_WIDTH / 8);
    localparam int unsigned           IDX_WIDTH = (RAM_SIZE > 1) ? $clog2(RAM_SIZE) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_SIZE - 1);
    localparam bit                    DO_INIT   = (INIT_ON_RESET != 0);

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] init_cnt;
    logic [DATA_WIDTH-1:0] mem [RAM_SIZE];

    logic                  init_wr_c;
    logic                  wr_ok_c;
    logic                  rd_ok_c;
    logic [DATA_WIDTH-1:0] rd_word_c;

    logic                  s1_valid;
    logic [DATA_WIDTH-1:0] s1_data;

    // Requests are only honoured in READY with reset released; out-of-range writes drop.
    assign init_wr_c = rst_b && (state == ST_INIT);
    assign wr_ok_c   = rst_b && (state == ST_READY) && we && (32'(write_addr) < RAM_SIZE);
    assign rd_ok_c   = rst_b && (state == ST_READY) && rd;

    // Read word with write-first bypass; out-of-range reads return zero.
    always_comb begin
        rd_word_c = '0;
        if (32'(read_addr) < RAM_SIZE) begin
            rd_word_c = mem[IDX_WIDTH'(read_addr)];
            if (wr_ok_c && (write_addr == read_addr)) begin
                for (int i = 0; i < BE_WIDTH; i++) begin
                    if (be[i]) begin
                        rd_word_c[8*i +: 8] = data_in[8*i +: 8];
                    end
                end
            end
        end
    end

    // Storage: no reset, cleared only by the fill sequence.
    always_ff @(posedge clk) begin
        if (init_wr_c) begin
            mem[IDX_WIDTH'(init_cnt)] <= '0;
        end else if (wr_ok_c) begin
            for (int i = 0; i < BE_WIDTH; i++) begin
                if (be[i]) begin
                    mem[IDX_WIDTH'(write_addr)][8*i +: 8] <= data_in[8*i +: 8];
                end
            end
        end
    end

    // Fill sequencer: one address per cycle, then hand over to normal operation.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state     <= DO_INIT ? ST_INIT : ST_READY;
            init_cnt  <= '0;
            init_busy <= DO_INIT;
        end else begin
            case (state)
                ST_INIT: begin
                    init_cnt <= init_cnt + ADDR_WIDTH'(1);
                    if (init_cnt == LAST_ADDR) begin
                        state     <= ST_READY;
                        init_busy <= 1'b0;
                        init_cnt  <= '0;
                    end
                end
                default: begin
                    state <= ST_READY;
                end
            endcase
        end
    end

    // First read stage: data only advances on an accepted read so it holds otherwise.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= rd_ok_c;
            if (rd_ok_c) begin
                s1_data <= rd_word_c;
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            always_ff @(posedge clk or negedge rst_b) begin
                if (!rst_b) begin
                    data_valid <= 1'b0;
                    data_out   <= '0;
                end else begin
                    data_valid <= s1_valid;
                    if (s1_valid) begin
                        data_out <= s1_data;
                    end
                end
            end
        end else begin : g_lat1
            assign data_valid = s1_valid;
            assign data_out   = s1_data;
        end
    endgenerate

endmodule

// File: tb/tb_dpram_rw_pipe.sv
// Bench for dpram_rw_pipe: latency-1 and latency-2 instances share one stimulus
// stream and are checked every cycle against a word-level memory model.
module tb_dpram_rw_pipe;

    localparam int unsigned N  = 20;
    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;

    logic          clk;
    logic          rst_b;
    logic          we;
    logic [3:0]    be;
    logic [AW-1:0] write_addr;
    logic [DW-1:0] data_in;
    logic          rd;
    logic [AW-1:0] read_addr;

    logic [DW-1:0] dout1, dout2;
    logic          dv1, dv2, busy1, busy2;

    int checks = 0;
    int errors = 0;

    // Model state
    logic [DW-1:0] mmem [N];
    int            fill_left = N;
    logic          exp_busy = 1'b1;
    logic [DW-1:0] exp1_d = '0, exp2_d = '0, p_d = '0;
    logic          exp1_v = 1'b0, exp2_v = 1'b0, p_v = 1'b0;

    dpram_rw_pipe #(.RAM_SIZE(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                    .READ_LATENCY(1), .INIT_ON_RESET(1)) u_dut1 (
        .clk(clk), .rst_b(rst_b), .we(we), .be(be), .write_addr(write_addr),
        .data_in(data_in), .rd(rd), .read_addr(read_addr),
        .data_out(dout1), .data_valid(dv1), .init_busy(busy1)
    );

    dpram_rw_pipe #(.RAM_SIZE(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                    .READ_LATENCY(2), .INIT_ON_RESET(1)) u_dut2 (
        .clk(clk), .rst_b(rst_b), .we(we), .be(be), .write_addr(write_addr),
        .data_in(data_in), .rd(rd), .read_addr(read_addr),
        .data_out(dout2), .data_valid(dv2), .init_busy(busy2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                            input logic [DW-1:0] new_w,
                                            input logic [3:0] en);
        logic [DW-1:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) begin
            if (en[i]) r[8*i +: 8] = new_w[8*i +: 8];
        end
        return r;
    endfunction

    // One clock: update the model from the sampled inputs, then compare both DUTs.
    task automatic step();
        logic          rv;
        logic [DW-1:0] rdat;
        @(posedge clk);
        rv   = 1'b0;
        rdat = '0;
        if (!rst_b) begin
            fill_left = N;
            exp_busy  = 1'b1;
            exp1_v = 1'b0; exp1_d = '0;
            exp2_v = 1'b0; exp2_d = '0;
            p_v    = 1'b0; p_d    = '0;
        end else begin
            if (fill_left > 0) begin
                mmem[N - fill_left] = '0;
                fill_left--;
                exp_busy = (fill_left > 0);
            end else begin
                if (rd) begin
                    rv = 1'b1;
                    if (read_addr < N) begin
                        rdat = mmem[read_addr];
                        if (we && write_addr == read_addr) rdat = merge(rdat, data_in, be);
                    end
                end
                if (we && write_addr < N) mmem[write_addr] = merge(mmem[write_addr], data_in, be);
            end
            exp2_v = p_v;
            if (p_v) exp2_d = p_d;
            p_v = rv;
            if (rv) p_d = rdat;
            exp1_v = rv;
            if (rv) exp1_d = rdat;
        end
        #1;
        check("busy1", 32'(busy1), 32'(exp_busy));
        check("busy2", 32'(busy2), 32'(exp_busy));
        check("valid1", 32'(dv1), 32'(exp1_v));
        check("valid2", 32'(dv2), 32'(exp2_v));
        if (!exp_busy) begin
            check("data1", dout1, exp1_d);
            check("data2", dout2, exp2_d);
        end
    endtask

    // Count cycles with init_busy high from now, bounded.
    task automatic count_busy(output int nbusy, output int ndv);
        nbusy = 0;
        ndv   = 0;
        for (int i = 0; i < 60; i++) begin
            if (!busy1) break;
            nbusy++;
            if (dv1 || dv2) ndv++;
            step();
        end
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] en);
        we = 1'b1; write_addr = a; data_in = d; be = en;
        step();
        we = 1'b0; be = 4'h0;
    endtask

    int nb, nd;

    initial begin
        rst_b = 1'b0; we = 1'b0; be = 4'h0; write_addr = '0; data_in = '0;
        rd = 1'b1; read_addr = 5'd5;

        // Reset state
        step(); step();
        check("rst_data1", dout1, 32'h0);
        check("rst_valid2", 32'(dv2), 32'h0);
        check("rst_busy1", 32'(busy1), 32'h1);

        // Fill with a read held at address 5
        rst_b = 1'b1;
        count_busy(nb, nd);
        check("init_busy_cycles", 32'(nb), 32'd20);
        check("init_no_valid", 32'(nd), 32'd0);
        step();
        check("first_read_valid", 32'(dv1), 32'h1);
        check("first_read_data", dout1, 32'h0);
        rd = 1'b0;
        step();

        // Byte enables
        wr(5'd3, 32'hAABBCCDD, 4'b1111);
        wr(5'd3, 32'h11223344, 4'b0010);
        rd = 1'b1; read_addr = 5'd3;
        step();
        check("be_merge", dout1, 32'hAABB33DD);
        rd = 1'b0;
        step(); step();

        // Write-first collision
        wr(5'd7, 32'hFFFFFFFF, 4'b1111);
        we = 1'b1; write_addr = 5'd7; data_in = 32'h12345678; be = 4'b0011;
        rd = 1'b1; read_addr = 5'd7;
        step();
        check("collide_lat1", dout1, 32'hFFFF5678);
        we = 1'b0; be = 4'h0; rd = 1'b0;
        step();
        check("collide_lat2", dout2, 32'hFFFF5678);
        check("hold_valid1", 32'(dv1), 32'h0);
        step();

        // Back-to-back reads through the two-stage pipe
        wr(5'd1, 32'h1, 4'hF);
        wr(5'd2, 32'h2, 4'hF);
        wr(5'd3, 32'h3, 4'hF);
        rd = 1'b1; read_addr = 5'd1; step();
        check("b2b_v0", 32'(dv2), 32'h0);
        read_addr = 5'd2; step();
        check("b2b_d1", dout2, 32'h1);
        read_addr = 5'd3; step();
        check("b2b_d2", dout2, 32'h2);
        rd = 1'b0; step();
        check("b2b_d3", dout2, 32'h3);
        check("b2b_v3", 32'(dv2), 32'h1);
        step();
        check("b2b_end", 32'(dv2), 32'h0);

        // Out of range, zero enables, independent read/write
        wr(5'd25, 32'hDEADBEEF, 4'hF);
        wr(5'd1, 32'hCAFEF00D, 4'h0);
        rd = 1'b1; read_addr = 5'd25; step();
        check("oor_data", dout1, 32'h0);
        check("oor_valid", 32'(dv1), 32'h1);
        read_addr = 5'd1; step();
        check("be_zero", dout1, 32'h1);
        we = 1'b1; write_addr = 5'd4; data_in = 32'h0BADCAFE; be = 4'hF;
        read_addr = 5'd3; step();
        we = 1'b0; be = 4'h0;
        for (int a = 0; a < 20; a++) begin
            read_addr = AW'(a);
            step();
        end
        rd = 1'b0; step(); step();

        // Reset with a read in flight
        rd = 1'b1; read_addr = 5'd3; step();
        rst_b = 1'b0; rd = 1'b0; step();
        check("abort_valid2", 32'(dv2), 32'h0);

        // Reset in the middle of the fill
        rst_b = 1'b1;
        for (int i = 0; i < 7; i++) step();
        rst_b = 1'b0; step();
        check("midinit_data1", dout1, 32'h0);
        check("midinit_data2", dout2, 32'h0);
        check("midinit_busy", 32'(busy1), 32'h1);
        rst_b = 1'b1;
        count_busy(nb, nd);
        check("refill_cycles", 32'(nb), 32'd20);
        rd = 1'b1; read_addr = 5'd3; step();
        check("refill_zero", dout1, 32'h0);
        rd = 1'b0; step(); step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
